// File: rtl/noc_vc_output_scheduler.sv
// Credit-based round-robin VC scheduler feeding one output link from per-VC flit FIFOs.
// Optional wormhole packet lock is enabled by defining NOC_VC_SCHED_PKT_LOCK_EN.
module noc_vc_output_scheduler #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned FLIT_WIDTH = 34,
    parameter int unsigned CREDITS    = 8,
    localparam int unsigned CW        = $clog2(CREDITS + 1)
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst_n,
    input  logic                           i_clear,
    input  logic [CHANNELS-1:0]            i_vc_empty,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_vc_flit,
    output logic [CHANNELS-1:0]            o_vc_pop,
    output logic [CHANNELS-1:0]            o_link_valid,
    output logic [FLIT_WIDTH-1:0]          o_link_flit,
    input  logic                           i_link_ready,
    input  logic [CHANNELS-1:0]            i_credit_return,
    output logic [CHANNELS*CW-1:0]         o_credit_cnt,
    output logic                           o_credit_err
);

    localparam int unsigned PW = $clog2(CHANNELS);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

    logic                  w_rst;
    logic [CW-1:0]         r_cnt [CHANNELS];
    logic [PW-1:0]         r_ptr;
    logic                  r_credit_err;
    logic [CHANNELS-1:0]   w_lock_mask;
    logic [CHANNELS-1:0]   w_elig;
    logic [CHANNELS-1:0]   w_grant;
    logic [PW-1:0]         w_grant_idx;
    logic [PW-1:0]         w_ptr_nxt;
    logic                  w_any;
    logic                  w_xfer;
    logic [FLIT_WIDTH-1:0] w_flit;

    // Clear behaves exactly like reset, including gating the outputs in that cycle.
    assign w_rst = !noc_rst_n || i_clear;

`ifdef NOC_VC_SCHED_PKT_LOCK_EN
    typedef enum logic {StIdle, StLocked} state_e;

    state_e        r_state, w_state_nxt;
    logic [PW-1:0] r_lock_vc, w_lock_vc_nxt;
    logic          w_head, w_tail;

    assign w_head = w_flit[FLIT_WIDTH-1];
    assign w_tail = w_flit[FLIT_WIDTH-2];

    always_comb begin
        w_lock_mask = '1;
        if (r_state == StLocked) begin
            w_lock_mask            = '0;
            w_lock_mask[r_lock_vc] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lock_vc_nxt = r_lock_vc;
        case (r_state)
            StIdle: begin
                // Single-flit packets (head and tail set) never take the lock.
                if (w_xfer && w_head && !w_tail) begin
                    w_state_nxt   = StLocked;
                    w_lock_vc_nxt = w_grant_idx;
                end
            end
            StLocked: begin
                if (w_xfer && w_tail) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (w_rst) begin
            r_state   <= StIdle;
            r_lock_vc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_vc <= w_lock_vc_nxt;
        end
    end
`else
    assign w_lock_mask = '1;
`endif

    always_comb begin
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            w_elig[v] = !i_vc_empty[v] && (r_cnt[v] != '0) && w_lock_mask[v];
        end
    end

    always_comb begin
        int unsigned idx;
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        idx         = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = (32'(r_ptr) + i) % CHANNELS;
            if (!w_any && w_elig[idx]) begin
                w_any       = 1'b1;
                w_grant_idx = PW'(idx);
            end
        end
        if (w_rst) begin
            w_any = 1'b0;
        end
        if (w_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_flit = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (w_grant[v]) begin
                w_flit = i_vc_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    assign o_link_valid = w_grant;
    assign o_link_flit  = w_flit;
    assign o_vc_pop     = w_grant & {CHANNELS{i_link_ready}};
    assign w_xfer       = w_any && i_link_ready;
    assign w_ptr_nxt    = (w_grant_idx == PW'(CHANNELS - 1)) ? '0 : w_grant_idx + PW'(1);

    always_ff @(posedge noc_clk) begin
        if (w_rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // A simultaneous send and return cancel out, so only an unmatched return can overflow.
    always_ff @(posedge noc_clk) begin
        if (w_rst) begin
            for (int unsigned v = 0; v < CHANNELS; v++) begin
                r_cnt[v] <= CREDITS_MAX;
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < CHANNELS; v++) begin
                if (o_vc_pop[v] && !i_credit_return[v]) begin
                    r_cnt[v] <= r_cnt[v] - CW'(1);
                end else if (!o_vc_pop[v] && i_credit_return[v]) begin
                    if (r_cnt[v] == CREDITS_MAX) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_cnt[v] <= r_cnt[v] + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            o_credit_cnt[v*CW +: CW] = r_cnt[v];
        end
    end

    assign o_credit_err = r_credit_err;

endmodule
